// File: rtl/launch_inst_queue.sv
// Dual-lane circular instruction queue between fetch and launch.
// Accepts up to two instructions per cycle, presents the two oldest entries
// to launch, and retires 0/1/2 entries per cycle. Branch and exception
// flushes clear the queue.
module launch_inst_queue #(
  parameter int DEPTH  = 8,
  parameter int LINE_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line1_pre_to_now_valid_i,
  input  logic                line2_pre_to_now_valid_i,
  input  logic [2*LINE_W-1:0] pre_to_ibus,
  output logic                allowin_o,
  input  logic                now_allowin_i,
  input  logic                double_valid_inst_lunch_flag_i,
  input  logic                single_valid_inst_lunch_flag_i,
  input  logic                zero_valid_inst_lunch_flag_i,
  input  logic                branch_flush_i,
  input  logic                excep_flush_i,
  output logic                line1_now_valid_o,
  output logic                line2_now_valid_o,
  output logic [2*LINE_W-1:0] to_id_obus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_p1, tail_p1;
  logic [1:0]        npush, npop_req, npop;
  logic              flush;
  logic              we_lane1, we_lane2;
  logic [LINE_W-1:0] lane1_in, lane2_in;

  // "Issue nothing" is simply the absence of the other two flags.
  logic unused_zero_flag;
  assign unused_zero_flag = zero_valid_inst_lunch_flag_i;

  assign lane1_in = pre_to_ibus[LINE_W-1:0];
  assign lane2_in = pre_to_ibus[2*LINE_W-1:LINE_W];
  assign head_p1  = head_q + PTR_W'(1);
  assign tail_p1  = tail_q + PTR_W'(1);

  // Room for a full two-wide push; depends on registered count only.
  assign allowin_o = (count_q <= CNT_W'(DEPTH - 2));

  // Decode push/pop amounts; lane2 without lane1 is ignored, pops clamp to count.
  always_comb begin
    npush = 2'd0;
    if (allowin_o && line1_pre_to_now_valid_i)
      npush = line2_pre_to_now_valid_i ? 2'd2 : 2'd1;
    npop_req = 2'd0;
    if (now_allowin_i) begin
      if (double_valid_inst_lunch_flag_i)      npop_req = 2'd2;
      else if (single_valid_inst_lunch_flag_i) npop_req = 2'd1;
    end
    npop = (CNT_W'(npop_req) > count_q) ? count_q[1:0] : npop_req;
    flush    = excep_flush_i || (branch_flush_i && now_allowin_i);
    we_lane1 = !flush && (npush != 2'd0);
    we_lane2 = !flush && (npush == 2'd2);
  end

  // Next-state pointers and occupancy; a flush drops everything including the push.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(npop);
      tail_d  = tail_q + PTR_W'(npush);
      count_d = count_q + CNT_W'(npush) - CNT_W'(npop);
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (we_lane1) mem_q[tail_q]  <= lane1_in;
    if (we_lane2) mem_q[tail_p1] <= lane2_in;
  end

  // Present the two oldest entries, zeroing any lane that is not valid.
  always_comb begin
    line1_now_valid_o = (count_q != '0);
    line2_now_valid_o = (count_q >= CNT_W'(2));
    to_id_obus = '0;
    if (line1_now_valid_o) to_id_obus[LINE_W-1:0]        = mem_q[head_q];
    if (line2_now_valid_o) to_id_obus[2*LINE_W-1:LINE_W] = mem_q[head_p1];
  end

endmodule

// File: tb/tb_launch_inst_queue.sv
module tb_launch_inst_queue;

  localparam int DEPTH  = 8;
  localparam int LINE_W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l1v, l2v;
  logic [127:0] ibus;
  logic         allowin;
  logic         now_allowin;
  logic         dbl, sgl, zro;
  logic         bflush, eflush;
  logic         l1v_o, l2v_o;
  logic [127:0] obus;

  int n_checks = 0;
  int n_errors = 0;

  launch_inst_queue #(.DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .line1_pre_to_now_valid_i       (l1v),
    .line2_pre_to_now_valid_i       (l2v),
    .pre_to_ibus                    (ibus),
    .allowin_o                      (allowin),
    .now_allowin_i                  (now_allowin),
    .double_valid_inst_lunch_flag_i (dbl),
    .single_valid_inst_lunch_flag_i (sgl),
    .zero_valid_inst_lunch_flag_i   (zro),
    .branch_flush_i                 (bflush),
    .excep_flush_i                  (eflush),
    .line1_now_valid_o              (l1v_o),
    .line2_now_valid_o              (l2v_o),
    .to_id_obus                     (obus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int n);
    return {32'h1c000000 + 32'(n * 4), 32'h02800000 + 32'(n)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input int a);
    l1v = 1'b1; l2v = 1'b1; ibus = {mk(a + 1), mk(a)};
  endtask

  task automatic push1(input int a);
    l1v = 1'b1; l2v = 1'b0; ibus = {64'h0, mk(a)};
  endtask

  task automatic idle();
    l1v = 1'b0; l2v = 1'b0; ibus = '0;
    now_allowin = 1'b0; dbl = 1'b0; sgl = 1'b0; zro = 1'b0;
    bflush = 1'b0; eflush = 1'b0;
  endtask

  // Pop one entry per cycle until empty, checking order and total.
  task automatic drain(input int first, input int exp_n, input string tag);
    int k;
    k = 0;
    idle();
    now_allowin = 1'b1; sgl = 1'b1;
    while (l1v_o && k <= DEPTH) begin
      chk({tag, "_lane1"}, {64'h0, obus[63:0]}, {64'h0, mk(first + k)});
      step();
      k++;
    end
    idle();
    chk({tag, "_count"}, 128'(k), 128'(exp_n));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_l1v", 128'(l1v_o), 128'(0));
    chk("rst_l2v", 128'(l2v_o), 128'(0));
    chk("rst_bus", obus, 128'h0);
    chk("rst_allowin", 128'(allowin), 128'(1));
    rst_n = 1'b1;

    // First two-wide push, visible one cycle later
    push2(0); step();
    chk("push_l1v", 128'(l1v_o), 128'(1));
    chk("push_l2v", 128'(l2v_o), 128'(1));
    chk("push_bus", obus, {mk(1), mk(0)});
    chk("push_pc", 128'(obus[63:32]), 128'(32'h1c000000));

    // Fill to DEPTH with no pops
    push2(2); step();
    push2(4); step();
    chk("cnt6_allowin", 128'(allowin), 128'(1));
    push2(6); step();
    chk("full_allowin", 128'(allowin), 128'(0));
    push2(8); step();
    chk("full_ignored_bus", obus, {mk(1), mk(0)});
    chk("full_ignored_allowin", 128'(allowin), 128'(0));
    drain(0, 8, "full_drain");

    // Move head to 6 with 3 entries, then steady double pop + double push across wrap
    push2(10); step(); push2(12); step(); push2(14); step();
    idle(); now_allowin = 1'b1; dbl = 1'b1;
    step(); step(); step();
    idle();
    push2(16); step();
    push1(18); step();
    idle();
    chk("wrap_pre_bus", obus, {mk(17), mk(16)});
    now_allowin = 1'b1; dbl = 1'b1;
    push2(19); step();
    chk("wrap1_bus", obus, {mk(19), mk(18)});
    push2(21); step();
    chk("wrap2_bus", obus, {mk(21), mk(20)});
    push2(23); step();
    chk("wrap3_bus", obus, {mk(23), mk(22)});
    chk("wrap3_allowin", 128'(allowin), 128'(1));
    drain(22, 3, "wrap_drain");

    // count=1 with double pop: clamp to 1, then empty pop is harmless
    push1(25); step();
    idle();
    chk("one_l2v", 128'(l2v_o), 128'(0));
    chk("one_bus", obus, {64'h0, mk(25)});
    now_allowin = 1'b1; dbl = 1'b1; step();
    chk("clamp_l1v", 128'(l1v_o), 128'(0));
    chk("clamp_l2v", 128'(l2v_o), 128'(0));
    chk("clamp_bus", obus, 128'h0);
    step();
    chk("empty_pop_allowin", 128'(allowin), 128'(1));
    idle();
    push2(26); step();
    idle();
    chk("no_underflow_bus", obus, {mk(27), mk(26)});

    // Branch flush with launch completing: everything dropped including the push
    push2(28); step(); push1(30); step();
    idle();
    bflush = 1'b1; now_allowin = 1'b1; dbl = 1'b1;
    push2(31); step();
    idle();
    chk("bflush_l1v", 128'(l1v_o), 128'(0));
    chk("bflush_allowin", 128'(allowin), 128'(1));
    push2(33); step();
    idle();
    chk("bflush_after_bus", obus, {mk(34), mk(33)});

    // Branch flush while launch stalls: no effect, push accepted
    push2(35); step(); push1(37); step();
    idle();
    bflush = 1'b1;
    push2(38); step();
    idle();
    chk("bstall_bus", obus, {mk(34), mk(33)});
    chk("bstall_allowin", 128'(allowin), 128'(0));
    drain(33, 7, "bstall_drain");

    // Exception flush beats pop and push
    push2(40); step(); push2(42); step(); push2(44); step();
    idle();
    eflush = 1'b1; bflush = 1'b1; now_allowin = 1'b1; dbl = 1'b1;
    push2(46); step();
    idle();
    chk("eflush_l1v", 128'(l1v_o), 128'(0));
    chk("eflush_allowin", 128'(allowin), 128'(1));
    push2(48); step();
    idle();
    chk("eflush_after_bus", obus, {mk(49), mk(48)});

    // Lane2 valid without lane1 writes nothing
    l1v = 1'b0; l2v = 1'b1; ibus = {mk(50), mk(50)}; step();
    idle();
    chk("lane2_only_bus", obus, {mk(49), mk(48)});
    drain(48, 2, "lane2_only_drain");

    // Full + pop: allowin stays low that cycle, so the push is dropped
    push2(51); step(); push2(53); step(); push2(55); step(); push2(57); step();
    idle();
    chk("refull_allowin", 128'(allowin), 128'(0));
    now_allowin = 1'b1; dbl = 1'b1;
    push2(59); step();
    idle();
    chk("pop_full_allowin", 128'(allowin), 128'(1));
    chk("pop_full_bus", obus, {mk(54), mk(53)});
    drain(53, 6, "pop_full_drain");

    // Asynchronous reset in the middle of a push
    push2(61); step();
    chk("prerst_l1v", 128'(l1v_o), 128'(1));
    push2(63);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_l1v", 128'(l1v_o), 128'(0));
    chk("async_rst_l2v", 128'(l2v_o), 128'(0));
    chk("async_rst_bus", obus, 128'h0);
    chk("async_rst_allowin", 128'(allowin), 128'(1));
    #3 rst_n = 1'b1;
    idle();
    step();
    chk("post_rst_l1v", 128'(l1v_o), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/launch_inst_queue.md
Name: launch_inst_queue

Overview:
Dual-lane circular instruction queue sitting directly upstream of the launch (issue) stage. It accepts up to two fetched instructions per cycle from the fetch stage. It presents the two oldest entries to launch as line1/line2 and retires 0, 1 or 2 entries per cycle according to launch's issue decision. It is also cleared by branch and exception flushes.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4.
LINE_W, 64, per-lane payload width: {pc[63:32], inst[31:0]}.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
line1_pre_to_now_valid_i  in  1  fetch lane1 instruction valid
line2_pre_to_now_valid_i  in  1  fetch lane2 instruction valid
pre_to_ibus  in  2*LINE_W  {lane2, lane1} payload from fetch
allowin_o  out  1  queue can accept a 2-instruction push this cycle
now_allowin_i  in  1  launch stage completes its work this cycle (pop qualifier)
double_valid_inst_lunch_flag_i  in  1  launch issues head and head+1
single_valid_inst_lunch_flag_i  in  1  launch issues head only
zero_valid_inst_lunch_flag_i  in  1  launch issues nothing (informational; pop 0)
branch_flush_i  in  1  branch redirect from launch
excep_flush_i  in  1  exception flush from writeback
line1_now_valid_o  out  1  head entry valid
line2_now_valid_o  out  1  head+1 entry valid
to_id_obus  out  2*LINE_W  {entry[head+1], entry[head]}

Behaviour:
- Storage: DEPTH x LINE_W register array; head ptr, tail ptr (log2(DEPTH) bits, wrap modulo DEPTH); count (log2(DEPTH)+1 bits, 0..DEPTH).
- Reset (async, rst_n=0): head=0, tail=0, count=0. Outputs: line1/line2_now_valid_o=0, to_id_obus=0, allowin_o=1. Array contents need no reset. Reset mid-operation discards all entries immediately.
- allowin_o = (DEPTH - count >= 2); combinational from registered count only, never from pop inputs.
- Push, effective when allowin_o=1:
  - line1_valid=1, line2_valid=0: write lane1 at tail; tail+=1.
  - both valid: lane1 at tail, lane2 at tail+1; tail+=2.
  - line2_valid=1 with line1_valid=0 is a protocol violation; the push is ignored and nothing is written.
  - When allowin_o=0, fetch valids are ignored.
- Pop, effective only when now_allowin_i=1:
  - npop=2 if double flag, else 1 if single flag, else 0.
  - npop is clamped to count (double with count=1 pops 1; single with count=0 pops 0).
  - head+=npop.
- Outputs, combinational from registered state:
  - line1_now_valid_o = (count>=1); line2_now_valid_o = (count>=2).
  - to_id_obus lane1 = entry[head], lane2 = entry[(head+1) mod DEPTH].
  - A lane's payload is forced to 0 when its valid is 0.
- Simultaneous push and pop in the same cycle: count_next = count + npush - npop. The pop reads old head entries; the push writes new tail entries. No bypass: an entry pushed in cycle N is visible at the output in cycle N+1 (1-cycle latency).
- branch_flush_i=1 with now_allowin_i=1: the issuing entries are consumed (launch already sampled them); all remaining entries are discarded; any same-cycle push is discarded. Next state: head=tail, count=0.
- branch_flush_i=1 with now_allowin_i=0: no effect this cycle (state held, push still obeys allowin_o).
- excep_flush_i=1: unconditional clear (head=tail, count=0) and same-cycle push discarded. It has priority over the branch flush and over push/pop.
- Full (count=DEPTH or DEPTH-1): allowin_o=0; a pop in the same cycle does not reopen allowin until the next cycle.
- Empty: both valids 0; pop flags are ignored via the clamp.
- Flags are mutually exclusive by contract. If double and single are both asserted, double wins.

Test Plan:
- Reset then push both lanes {pc=0x1c000000,inst=0x02800000},{pc=0x1c000004,...} -> next cycle both valids=1, lane1 pc=0x1c000000, count=2.
- Push 2/cycle with now_allowin_i=0 for 4 cycles (DEPTH=8) -> count=8, allowin_o=0. A 5th push is ignored and the contents are unchanged.
- Queue holds 3 entries at head=6. Double pop plus 2-push for 3 cycles -> head and tail wrap 7->0. Output pc sequence stays strictly in order; count stays 3.
- count=1, double flag, now_allowin_i=1 -> pops 1, count=0, both valids 0 next cycle; no underflow.
- count=5, branch_flush_i=1 with now_allowin_i=1, simultaneous push -> next cycle count=0, valids 0. Repeat with now_allowin_i=0 -> count=7 (push accepted, no flush).
- count=6, excep_flush_i=1 with double pop and push -> count=0. Then deassert rst_n mid-push -> outputs zero immediately (asynchronous), allowin_o=1.
